mem_refill_arbiter: RTL and testbench
=====================================

# mem_refill_arbiter

Sequencing controller that shares the single backing main memory between the instruction-cache and data-cache miss paths of the pipelined MIPS core. It accepts level-held miss requests from both sides and arbitrates round-robin. It runs either a block refill burst (read) or a single-word write-through, then signals completion with a one-cycle done pulse. It sits between the two cache controllers and the main-memory port inside the memory-with-cache subsystem.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- BLOCK_WORDS, 4, words per cache block (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  I-side miss request, held until i_done
- i_addr  in  ADDR_W  I-side miss address (any byte in block)
- i_rvalid  out  1  refill word valid for I-side
- i_rdata  out  DATA_W  refill word
- i_widx  out  log2(BLOCK_WORDS)  index of word within block
- i_done  out  1  one-cycle completion pulse
- d_req  in  1  D-side request, held until d_done
- d_we  in  1  1 = single-word write, 0 = block refill; stable while d_req
- d_addr  in  ADDR_W  D-side address
- d_wdata  in  DATA_W  write data
- d_rvalid, d_rdata, d_widx, d_done  out  as I-side
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  access complete (may assert the same cycle as mem_en)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, BURST, WRITE, DONE.
- IDLE: one requester pending → grant it. Both pending → grant the one not granted last. last_grant resets to I, so the first tie goes to D.
- Grant with a read → BURST. The base address is req_addr with the low log2(BLOCK_WORDS)+2 bits zeroed; the word counter is cleared.
- Grant with D write → WRITE. mem_addr = d_addr with bits[1:0] zeroed; mem_wdata = d_wdata.
- BURST:
  - mem_en=1, mem_we=0, mem_addr = base + 4·cnt.
  - On mem_ack: grantee rvalid=1, rdata=mem_rdata, widx=cnt, all combinational in the same cycle. cnt increments.
  - The ack with cnt = BLOCK_WORDS-1 → DONE.
- WRITE: mem_en=1, mem_we=1 until mem_ack → DONE.
- DONE: grantee done=1 for exactly one cycle; mem_en=0; → IDLE. The requester deasserts req on the edge ending DONE, so IDLE never re-grants a stale request.
- No rvalid to the non-granted side, ever.
- mem_ack outside BURST/WRITE is ignored.
- Requests are never preempted. A request arriving mid-transaction waits.
- Counter arithmetic is modulo BLOCK_WORDS. The address increment does not carry into tag bits, because the base is block-aligned.

## Timing
- Reset values: state IDLE, cnt 0, last_grant I. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, rvalid/rdata/widx/done of both sides, busy.
- Request sampled in IDLE at edge t → mem_en high in cycle t+1.
- Zero-wait memory (mem_ack with mem_en): refill is 1 + BLOCK_WORDS + 1 cycles from the request edge to the end of the done pulse. A write is 3 cycles.
- Each wait cycle (mem_en high, mem_ack low) holds mem_addr, mem_wdata and cnt stable.
- Reset asserted mid-transaction:
  - Immediate return to reset values.
  - The transaction is abandoned and no done is issued.
  - Requesters must re-request after reset deasserts.
- Back-to-back: the earliest next grant is the IDLE cycle following DONE, so mem_en drops for at least one cycle (DONE) between transactions.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, BURST, WRITE, DONE}
  - grant enum {GNT_I, GNT_D}
  - OFFS_W = log2(BLOCK_WORDS)+2 helper constant
- One natural sub-module, rr_arbiter2: two-request round-robin with a last_grant register updated on grant.
- FSM, counter and output muxing stay in the top module.

## Test plan
- I refill, addr 0x0000_004C, zero-wait memory:
  - mem_addr 0x40, 0x44, 0x48, 0x4C on consecutive cycles.
  - i_widx 0..3 with i_rvalid.
  - i_done one cycle later; d_rvalid stays 0.
- D write, addr 0x0000_0103, data 0xDEADBEEF, mem_ack delayed 3 cycles:
  - mem_addr 0x100 and mem_we held 4 cycles.
  - d_done once; no rvalid on either side.
- i_req and d_req rise in the same cycle after reset:
  - D serviced first, then I.
  - A second D request raised during the I burst waits until I's DONE.
- D refill with alternating ack/no-ack: mem_addr and d_widx advance only on ack cycles; rdata matches the memory contents at 0x80..0x8C.
- reset pulsed during the BURST word-2 wait:
  - All outputs 0 asynchronously, no i_done.
  - Fresh i_req afterwards restarts at word 0.
- Continuous d_req with i_req pending: grants alternate D, I, D; neither side starves.

Source files
------------

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types and constants for the I/D-cache main-memory refill arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        WRITE,
        DONE
    } state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } grant_t;

    // Block offset width in bytes: word-index bits plus the two byte bits.
    function automatic int offs_w(input int block_words);
        return $clog2(block_words) + 2;
    endfunction

    localparam int OFFS_W = offs_w(4);

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// Bundle of the two cache-side request ports and the main-memory port.
interface mem_refill_arbiter_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [IDX_W-1:0]  i_widx;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [IDX_W-1:0]  d_widx;
    logic              d_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rvalid, i_rdata, i_widx, i_done,
        output d_rvalid, d_rdata, d_widx, d_done,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rvalid, i_rdata, i_widx, i_done,
        input  d_rvalid, d_rdata, d_widx, d_done,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_refill_arbiter_arb.sv
// Two-requester round-robin arbiter; last_grant advances only when the
// grant is actually taken by the sequencer.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   take,
    output logic   gnt_valid,
    output grant_t gnt
);

    grant_t last_grant;

    always_comb begin
        gnt_valid = req_i | req_d;
        gnt       = GNT_I;
        if (req_i && req_d) begin
            gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            gnt = GNT_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_I;
        end else if (take) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares main memory between I- and D-cache miss paths: block refill bursts
// or single-word write-through, each closed by a one-cycle done pulse.
//   state | meaning
//   IDLE  | waiting for a request, arbiter consulted
//   BURST | reading BLOCK_WORDS words for the grantee
//   WRITE | single D-side write, held until mem_ack
//   DONE  | one-cycle done pulse to the grantee
module mem_refill_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input logic                clk,
    input logic                reset,
    mem_refill_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFFS  = offs_w(BLOCK_WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK  = {ADDR_W{1'b1}} << OFFS;
    localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << 2;

    state_t            state, state_nxt;
    grant_t            gnt_q;
    grant_t            arb_gnt;
    logic              arb_valid;
    logic              grant_take;
    logic              is_write;
    logic [IDX_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] wdata_q;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (bus.i_req),
        .req_d     (bus.d_req),
        .take      (grant_take),
        .gnt_valid (arb_valid),
        .gnt       (arb_gnt)
    );

    assign grant_take = (state == IDLE) && arb_valid;
    assign req_addr   = (arb_gnt == GNT_D) ? bus.d_addr : bus.i_addr;
    assign is_write   = (arb_gnt == GNT_D) && bus.d_we;

    // Address and write data are captured at grant so wait cycles hold them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            gnt_q   <= GNT_I;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_take) begin
                gnt_q   <= arb_gnt;
                cnt     <= '0;
                addr_q  <= req_addr & (is_write ? WORD_MASK : BLK_MASK);
                wdata_q <= bus.d_wdata;
            end else if (state == BURST && bus.mem_ack) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_rdata   = '0;
        bus.i_widx    = '0;
        bus.i_done    = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.d_widx    = '0;
        bus.d_done    = 1'b0;
        bus.busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = is_write ? WRITE : BURST;
                end
            end
            BURST: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = addr_q + ADDR_W'({cnt, 2'b00});
                if (bus.mem_ack) begin
                    if (gnt_q == GNT_I) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_rdata;
                        bus.i_widx   = cnt;
                    end else begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                        bus.d_widx   = cnt;
                    end
                    if (cnt == IDX_W'(BLOCK_WORDS - 1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                if (bus.mem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (gnt_q == GNT_I) begin
                    bus.i_done = 1'b1;
                end else begin
                    bus.d_done = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: requester drivers push expected
// words/writes, a negedge monitor pops and compares them.
module tb_mem_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  widx;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dcmd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ack_ok = 1'b0;
    int   ack_mode = 0;
    int   waitc = 0;

    int errors = 0;
    int checks = 0;

    rd_t         i_exp[$];
    rd_t         d_exp[$];
    wr_t         wr_exp[$];
    logic [31:0] i_cmd[$];
    dcmd_t       d_cmd[$];
    int          done_log[$];
    bit          i_pend = 0;
    bit          d_pend = 0;
    int          we_cycles = 0;
    int          i_done_cnt = 0;
    int          d_done_cnt = 0;

    always #5 clk = ~clk;

    mem_refill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) bus ();

    mem_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign bus.mem_ack   = bus.mem_en & ack_ok;
    assign bus.mem_rdata = mem_val(bus.mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none @%0t", name, $time);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"},    bus.mem_en, 0);
        check({tag, "_mem_we"},    bus.mem_we, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_i_rvalid"},  bus.i_rvalid, 0);
        check({tag, "_i_rdata"},   bus.i_rdata, 0);
        check({tag, "_i_widx"},    bus.i_widx, 0);
        check({tag, "_i_done"},    bus.i_done, 0);
        check({tag, "_d_rvalid"},  bus.d_rvalid, 0);
        check({tag, "_d_rdata"},   bus.d_rdata, 0);
        check({tag, "_d_widx"},    bus.d_widx, 0);
        check({tag, "_d_done"},    bus.d_done, 0);
        check({tag, "_busy"},      bus.busy, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while ((i_cmd.size() != 0 || d_cmd.size() != 0 || bus.i_req || bus.d_req || bus.busy)
                   && n < 3000);
        if (n >= 3000) fail({tag, "_idle_timeout"});
    endtask

    // Memory acknowledge behaviour, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0: ack_ok = 1'b1;
            1: ack_ok = (waitc >= 3);
            2: ack_ok = ~ack_ok;
            3: ack_ok = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (bus.mem_en && !bus.mem_ack) waitc++;
        else waitc = 0;
    end

    // I-side requester.
    initial begin
        bus.i_req  = 1'b0;
        bus.i_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            while (i_cmd.size() != 0) begin
                logic [31:0] a, base;
                bit fin;
                int n;
                a = i_cmd.pop_front();
                base = a & ~32'(BW * 4 - 1);
                for (int k = 0; k < BW; k++)
                    i_exp.push_back('{addr: base + 32'(4 * k), widx: 2'(k), data: mem_val(base + 32'(4 * k))});
                i_pend = 1;
                bus.i_addr = a;
                bus.i_req = 1'b1;
                fin = 0;
                n = 0;
                while (!fin) begin
                    @(posedge clk);
                    #1;
                    if (reset) begin
                        bus.i_req = 1'b0;
                        fin = 1;
                    end else if (bus.i_done) begin
                        @(posedge clk);
                        #1;
                        bus.i_req = 1'b0;
                        fin = 1;
                    end else if (++n > 500) begin
                        fail("i_done_timeout");
                        bus.i_req = 1'b0;
                        fin = 1;
                    end
                end
                #1;
            end
        end
    end

    // D-side requester.
    initial begin
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        forever begin
            @(posedge clk);
            #2;
            while (d_cmd.size() != 0) begin
                dcmd_t c;
                logic [31:0] base;
                bit fin;
                int n;
                c = d_cmd.pop_front();
                if (c.we) begin
                    wr_exp.push_back('{addr: c.addr & ~32'h3, data: c.data});
                end else begin
                    base = c.addr & ~32'(BW * 4 - 1);
                    for (int k = 0; k < BW; k++)
                        d_exp.push_back('{addr: base + 32'(4 * k), widx: 2'(k), data: mem_val(base + 32'(4 * k))});
                end
                d_pend = 1;
                bus.d_we = c.we;
                bus.d_addr = c.addr;
                bus.d_wdata = c.data;
                bus.d_req = 1'b1;
                fin = 0;
                n = 0;
                while (!fin) begin
                    @(posedge clk);
                    #1;
                    if (reset) begin
                        bus.d_req = 1'b0;
                        fin = 1;
                    end else if (bus.d_done) begin
                        @(posedge clk);
                        #1;
                        bus.d_req = 1'b0;
                        fin = 1;
                    end else if (++n > 500) begin
                        fail("d_done_timeout");
                        bus.d_req = 1'b0;
                        fin = 1;
                    end
                end
                #1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents data, writes or done.
    initial begin
        logic prev_en, prev_ack, prev_we, prev_di, prev_dd;
        logic [31:0] prev_addr, prev_wdata;
        rd_t e;
        wr_t w;
        prev_en = 0; prev_ack = 0; prev_we = 0; prev_di = 0; prev_dd = 0;
        prev_addr = 0; prev_wdata = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 0;
                prev_di = 0;
                prev_dd = 0;
            end else begin
                check("busy", bus.busy, bus.mem_en | bus.i_done | bus.d_done);
                if (bus.i_rvalid && bus.d_rvalid) fail("both_rvalid");
                if (bus.i_rvalid) begin
                    if (i_exp.size() == 0) fail("i_rvalid_unexpected");
                    else begin
                        e = i_exp.pop_front();
                        check("i_word_addr", bus.mem_addr, e.addr);
                        check("i_widx", bus.i_widx, e.widx);
                        check("i_rdata", bus.i_rdata, e.data);
                    end
                end
                if (bus.d_rvalid) begin
                    if (d_exp.size() == 0) fail("d_rvalid_unexpected");
                    else begin
                        e = d_exp.pop_front();
                        check("d_word_addr", bus.mem_addr, e.addr);
                        check("d_widx", bus.d_widx, e.widx);
                        check("d_rdata", bus.d_rdata, e.data);
                    end
                end
                if (bus.mem_en && bus.mem_we) begin
                    we_cycles++;
                    if (bus.mem_ack) begin
                        if (wr_exp.size() == 0) fail("write_unexpected");
                        else begin
                            w = wr_exp.pop_front();
                            check("wr_addr", bus.mem_addr, w.addr);
                            check("wr_data", bus.mem_wdata, w.data);
                        end
                    end
                end
                if (prev_en && !prev_ack) begin
                    check("hold_en", bus.mem_en, 1);
                    check("hold_we", bus.mem_we, prev_we);
                    check("hold_addr", bus.mem_addr, prev_addr);
                    check("hold_wdata", bus.mem_wdata, prev_wdata);
                end
                if (bus.i_done) begin
                    check("i_done_pending", i_pend, 1);
                    check("i_done_words_left", i_exp.size(), 0);
                    check("i_done_pulse", prev_di, 0);
                    i_pend = 0;
                    i_done_cnt++;
                    done_log.push_back(0);
                end
                if (bus.d_done) begin
                    check("d_done_pending", d_pend, 1);
                    check("d_done_words_left", d_exp.size() + wr_exp.size(), 0);
                    check("d_done_pulse", prev_dd, 0);
                    d_pend = 0;
                    d_done_cnt++;
                    done_log.push_back(1);
                end
                prev_en = bus.mem_en;
                prev_ack = bus.mem_ack;
                prev_we = bus.mem_we;
                prev_addr = bus.mem_addr;
                prev_wdata = bus.mem_wdata;
                prev_di = bus.i_done;
                prev_dd = bus.d_done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, snap;
        int exp_tie[3];
        int exp_rr[5];
        exp_tie = '{1, 0, 1};
        exp_rr  = '{1, 0, 1, 0, 1};

        // Reset values, both during and right after reset.
        #12;
        check_zero("rst_held");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("rst_rel");

        // Simultaneous requests after reset: D wins first; D raised during I waits.
        ack_mode = 0;
        done_log.delete();
        d_cmd.push_back('{we: 1'b1, addr: 32'h0000_0300, data: 32'h1234_5678});
        i_cmd.push_back(32'h0000_0010);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!(done_log.size() == 1 && bus.mem_en) && n < 200);
        if (n >= 200) fail("tie_burst_timeout");
        d_cmd.push_back('{we: 1'b0, addr: 32'h0000_0024, data: 32'h0});
        wait_idle("tie");
        check("tie_count", done_log.size(), 3);
        for (int k = 0; k < 3; k++)
            if (k < done_log.size()) check("tie_order", done_log[k], exp_tie[k]);

        // I refill at 0x4C, zero-wait: latency and done timing.
        i_cmd.push_back(32'h0000_004C);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!bus.i_req && n < 50);
        @(posedge clk);
        #1;
        check("lat_mem_en", bus.mem_en, 1);
        check("lat_first_addr", bus.mem_addr, 32'h40);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("lat_i_done", bus.i_done, (k == 4) ? 1 : 0);
        end
        wait_idle("irefill");

        // D write at 0x103 with 3 wait cycles: held for 4 cycles.
        ack_mode = 1;
        we_cycles = 0;
        snap = d_done_cnt;
        d_cmd.push_back('{we: 1'b1, addr: 32'h0000_0103, data: 32'hDEAD_BEEF});
        wait_idle("dwrite");
        check("dwrite_we_cycles", we_cycles, 4);
        check("dwrite_done_count", d_done_cnt - snap, 1);

        // D refill at 0x80 with alternating acknowledge.
        ack_mode = 2;
        d_cmd.push_back('{we: 1'b0, addr: 32'h0000_0088, data: 32'h0});
        wait_idle("dalt");

        // Reset during the word-2 wait of an I burst.
        ack_mode = 4;
        ack_ok = 1'b1;
        snap = i_done_cnt;
        i_cmd.push_back(32'h0000_0200);
        n = 0;
        do begin
            @(posedge clk);
            #3;
            n++;
        end while (!bus.mem_en && n < 50);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ack_ok = 1'b0;
        check("mid_word2_addr", bus.mem_addr, 32'h208);
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #2;
        reset = 1'b0;
        i_exp.delete();
        i_pend = 0;
        ack_mode = 0;
        @(posedge clk);
        #3;
        check("rst_no_done", i_done_cnt - snap, 0);
        i_cmd.push_back(32'h0000_0200);
        wait_idle("rst_retry");
        check("rst_retry_done", i_done_cnt - snap, 1);

        // Continuous D with I pending: grants alternate.
        ack_mode = 3;
        done_log.delete();
        for (int k = 0; k < 3; k++)
            d_cmd.push_back('{we: 1'(k == 1), addr: 32'h0000_0400 + 32'(k * 20), data: $urandom});
        for (int k = 0; k < 2; k++)
            i_cmd.push_back(32'h0000_0600 + 32'(k * 36));
        wait_idle("rr");
        check("rr_count", done_log.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < done_log.size()) check("rr_order", done_log[k], exp_rr[k]);

        // Randomized traffic on both sides.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 1) == 1)
                i_cmd.push_back($urandom & 32'h0000_0FFF);
            if ($urandom_range(0, 1) == 1)
                d_cmd.push_back('{we: 1'($urandom_range(0, 1)), addr: $urandom & 32'h0000_0FFF,
                                  data: $urandom});
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #3;
        end
        wait_idle("random");
        check("final_i_left", i_exp.size(), 0);
        check("final_d_left", d_exp.size() + wr_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
